// File: rtl/keyb_pkg.sv
// keyb_pkg: shared FSM state type and default sizing for the keypad scanner.
// Consumed by keyb_row_enc and keyb_scan_gen.
package keyb_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_REL
  } keyb_state_e;

  localparam int DEF_N_ROWS          = 4;
  localparam int DEF_N_COLS          = 4;
  localparam int DEF_SCAN_DIV        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 8;
  localparam int DEF_REPEAT_CYCLES   = 64;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/keyb_row_enc.sv
// keyb_row_enc: classifies a row sense vector as none, exactly one
// or several rows active, and encodes the (highest) active row index.
module keyb_row_enc
  import keyb_pkg::*;
#(
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int RW     = $clog2(N_ROWS)
) (
  input  logic [N_ROWS-1:0] rows,
  output logic              onehot_ok,
  output logic              multi,
  output logic [RW-1:0]     row_index
);

  logic [3:0] pop;

  always_comb begin
    pop       = '0;
    row_index = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      if (rows[i]) begin
        pop       = pop + 4'd1;
        row_index = RW'(i);
      end
    end
    onehot_ok = (pop == 4'd1);
    multi     = (pop > 4'd1);
  end

endmodule

// File: rtl/keyb_scan_gen.sv
// keyb_scan_gen: keypad column scanner with press/release debounce.
// Define KEYB_REPEAT_EN to auto-repeat key_valid while a key is held.
module keyb_scan_gen
  import keyb_pkg::*;
#(
  parameter int N_ROWS          = DEF_N_ROWS,
  parameter int N_COLS          = DEF_N_COLS,
  parameter int SCAN_DIV        = DEF_SCAN_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  localparam int RW = $clog2(N_ROWS),
  localparam int CW = $clog2(N_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_ROWS-1:0]   rows_in,
  output logic [N_COLS-1:0]   cols_out,
  output logic                key_valid,
  output logic [RW+CW-1:0]    key_id,
  output logic                key_held,
  output logic                multi_err
);

  localparam int CNT_MAX =
    max3(SCAN_DIV, DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    COL_LAST = CW'(N_COLS - 1);

  logic [N_ROWS-1:0] rs_meta;
  logic [N_ROWS-1:0] rs;

  keyb_state_e       state;
  keyb_state_e       state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CW-1:0]     col_idx;
  logic [CW-1:0]     col_n;
  logic [CW-1:0]     col_next;
  logic [N_ROWS-1:0] cap_row;
  logic [N_ROWS-1:0] cap_row_n;
  logic [RW-1:0]     cap_idx;
  logic [RW-1:0]     cap_idx_n;

  logic              valid_n;
  logic [RW+CW-1:0]  id_n;
  logic              held_n;
  logic              merr_n;

  logic              enc_ok;
  logic              enc_multi;
  logic [RW-1:0]     enc_idx;
  logic              row_on;
  logic              row_match;

`ifdef KEYB_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DONE = CNT_W'(REPEAT_CYCLES);
  logic [CNT_W-1:0]  rpt;
  logic [CNT_W-1:0]  rpt_n;
  logic [CNT_W-1:0]  rpt_inc;
`endif

  // Row sense is asynchronous to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_meta <= '0;
      rs      <= '0;
    end else begin
      rs_meta <= rows_in;
      rs      <= rs_meta;
    end
  end

  keyb_row_enc #(
    .N_ROWS    (N_ROWS),
    .RW        (RW)
  ) u_row_enc (
    .rows      (rs),
    .onehot_ok (enc_ok),
    .multi     (enc_multi),
    .row_index (enc_idx)
  );

  assign cols_out  = {{(N_COLS-1){1'b0}}, 1'b1} << col_idx;
  assign row_on    = |(rs & cap_row);
  assign row_match = (rs == cap_row);

  assign cnt_inc  = (cnt == CNT_TOP) ? cnt : cnt + CNT_W'(1);
  assign col_next = (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);

`ifdef KEYB_REPEAT_EN
  assign rpt_inc = (rpt == CNT_TOP) ? rpt : rpt + CNT_W'(1);
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    col_n     = col_idx;
    cap_row_n = cap_row;
    cap_idx_n = cap_idx;
    valid_n   = 1'b0;
    id_n      = key_id;
    held_n    = key_held;
    merr_n    = 1'b0;
`ifdef KEYB_REPEAT_EN
    rpt_n     = rpt;
`endif
    unique case (state)
      SCAN: begin
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          if (enc_ok) begin
            state_n   = DEB_PRESS;
            cap_row_n = rs;
            cap_idx_n = enc_idx;
          end else begin
            col_n  = col_next;
            merr_n = enc_multi;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
      DEB_PRESS: begin
        if (!row_match) begin
          state_n = SCAN;
          cnt_n   = '0;
          col_n   = col_next;
        end else if (cnt_inc == DEB_DONE) begin
          state_n = HELD;
          cnt_n   = '0;
          valid_n = 1'b1;
          id_n    = {cap_idx, col_idx};
          held_n  = 1'b1;
`ifdef KEYB_REPEAT_EN
          rpt_n   = '0;
`endif
        end else begin
          cnt_n = cnt_inc;
        end
      end
      HELD: begin
        if (!row_on) begin
          state_n = DEB_REL;
          cnt_n   = '0;
        end
`ifdef KEYB_REPEAT_EN
        else if (rpt_inc == RPT_DONE) begin
          valid_n = 1'b1;
          rpt_n   = '0;
        end else begin
          rpt_n = rpt_inc;
        end
`endif
      end
      DEB_REL: begin
        // A returning row bit is a bounce, not a new press.
        if (row_on) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt_inc == DEB_DONE) begin
          state_n = SCAN;
          cnt_n   = '0;
          held_n  = 1'b0;
          col_n   = col_next;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      cnt       <= '0;
      col_idx   <= '0;
      cap_row   <= '0;
      cap_idx   <= '0;
      key_valid <= 1'b0;
      key_id    <= '0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      col_idx   <= col_n;
      cap_row   <= cap_row_n;
      cap_idx   <= cap_idx_n;
      key_valid <= valid_n;
      key_id    <= id_n;
      key_held  <= held_n;
      multi_err <= merr_n;
    end
  end

`ifdef KEYB_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt <= '0;
    end else begin
      rpt <= rpt_n;
    end
  end
`endif

endmodule

// File: tb/tb_keyb_scan_gen.sv
// tb_keyb_scan_gen: directed checks of keyb_scan_gen with a keypad model
// (4x4 defaults plus a 3x5 instance with REPEAT_CYCLES=16).
module tb_keyb_scan_gen;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] exp_id;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pressed;
  logic [14:0] pressed2;

  logic [3:0]  rows_in;
  logic [3:0]  cols_out;
  logic        key_valid;
  logic [3:0]  key_id;
  logic        key_held;
  logic        multi_err;

  logic [2:0]  rows2;
  logic [4:0]  cols2;
  logic        valid2;
  logic [4:0]  id2;
  logic        held2;
  logic        merr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    rows_in = '0;
    for (int r = 0; r < 4; r++)
      rows_in[r] = |(pressed[r*4 +: 4] & cols_out);
  end

  always_comb begin
    rows2 = '0;
    for (int r = 0; r < 3; r++)
      rows2[r] = |(pressed2[r*5 +: 5] & cols2);
  end

  keyb_scan_gen dut (
    .clk       (clk),
    .reset     (reset),
    .rows_in   (rows_in),
    .cols_out  (cols_out),
    .key_valid (key_valid),
    .key_id    (key_id),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  keyb_scan_gen #(
    .N_ROWS        (3),
    .N_COLS        (5),
    .REPEAT_CYCLES (16)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .rows_in   (rows2),
    .cols_out  (cols2),
    .key_valid (valid2),
    .key_id    (id2),
    .key_held  (held2),
    .multi_err (merr2)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(
    input  int         n,
    output int         pulses,
    output logic [3:0] id,
    output int         merr,
    output int         moves
  );
    logic [3:0] prev;
    pulses = 0;
    id     = '0;
    merr   = 0;
    moves  = 0;
    prev   = cols_out;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid) begin
        pulses++;
        id = key_id;
      end
      if (multi_err) merr++;
      if (cols_out != prev) moves++;
      prev = cols_out;
    end
  endtask

  // Release path: 2 sync cycles, 1 HELD cycle, DEBOUNCE_CYCLES in DEB_REL.
  task automatic release_chk(input string nm);
    pressed = '0;
    repeat (10) @(negedge clk);
    chk({nm, " held@10"}, 32'(key_held), 32'd1);
    @(negedge clk);
    chk({nm, " held@11"}, 32'(key_held), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    int         p;
    int         p2;
    int         m;
    int         mv;
    int         n;
    int         times[16];
    logic [3:0] id;
    logic [3:0] prev_c;
    logic [4:0] prev5;
    logic       found;
    logic       wrap;

    vecs[0] = '{2, 1, 4'b1001};
    vecs[1] = '{0, 0, 4'b0000};
    vecs[2] = '{3, 3, 4'b1111};
    vecs[3] = '{1, 2, 4'b0110};
    vecs[4] = '{0, 3, 4'b0011};
    vecs[5] = '{3, 0, 4'b1100};

    reset    = 1'b0;
    pressed  = '0;
    pressed2 = '0;
    repeat (3) @(negedge clk);
    chk("rst cols", 32'(cols_out), 32'h1);
    chk("rst valid", 32'(key_valid), 32'd0);
    chk("rst id", 32'(key_id), 32'd0);
    chk("rst held", 32'(key_held), 32'd0);
    chk("rst merr", 32'(multi_err), 32'd0);
    chk("rst cols2", 32'(cols2), 32'h1);

    reset = 1'b1;
    @(negedge clk);
    chk("dwell col0", 32'(cols_out), 32'h1);
    repeat (3) @(negedge clk);
    chk("rotate col1", 32'(cols_out), 32'h2);

    for (int v = 0; v < 6; v++) begin
      pressed[vecs[v].row*4 + vecs[v].col] = 1'b1;
      observe(50, p, id, m, mv);
      chk($sformatf("v%0d pulses", v), 32'(p), 32'd1);
      chk($sformatf("v%0d id", v), 32'(id), 32'(vecs[v].exp_id));
      chk($sformatf("v%0d held", v), 32'(key_held), 32'd1);
      chk($sformatf("v%0d merr", v), 32'(m), 32'd0);
      release_chk($sformatf("v%0d", v));
      chk($sformatf("v%0d id kept", v), 32'(key_id),
          32'(vecs[v].exp_id));
      observe(5, p, id, m, mv);
    end

    // Bouncing contact on row 3 / col 3.
    p2 = 0;
    pressed[15] = 1'b1;
    observe(2, p, id, m, mv);
    p2 += p;
    pressed[15] = 1'b0;
    observe(5, p, id, m, mv);
    p2 += p;
    pressed[15] = 1'b1;
    observe(4, p, id, m, mv);
    p2 += p;
    pressed[15] = 1'b0;
    observe(4, p, id, m, mv);
    p2 += p;
    chk("bounce no pulse", 32'(p2), 32'd0);
    pressed[15] = 1'b1;
    observe(60, p, id, m, mv);
    chk("bounce stable pulses", 32'(p), 32'd1);
    chk("bounce stable id", 32'(id), 32'hF);
    release_chk("bounce");
    observe(5, p, id, m, mv);

    // Two rows in column 0.
    pressed[0]  = 1'b1;
    pressed[12] = 1'b1;
    observe(40, p, id, m, mv);
    chk("multi seen", 32'(m >= 1), 32'd1);
    chk("multi no valid", 32'(p), 32'd0);
    chk("multi rotating", 32'(mv >= 4), 32'd1);
    pressed = '0;
    observe(6, p, id, m, mv);
    chk("multi clear valid", 32'(p), 32'd0);

    // Reset while a key is held.
    pressed[9] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (key_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstheld first pulse", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstheld valid", 32'(key_valid), 32'd0);
    chk("rstheld id", 32'(key_id), 32'd0);
    chk("rstheld held", 32'(key_held), 32'd0);
    chk("rstheld merr", 32'(multi_err), 32'd0);
    chk("rstheld cols", 32'(cols_out), 32'h1);
    prev_c = cols_out;
    repeat (3) @(negedge clk);
    chk("rstheld cols low", 32'(cols_out), 32'(prev_c));
    chk("rstheld held low", 32'(key_held), 32'd0);
    reset = 1'b1;
    observe(50, p, id, m, mv);
    chk("rstheld repress pulses", 32'(p), 32'd1);
    chk("rstheld repress id", 32'(id), 32'h9);
    release_chk("rstheld");
    observe(5, p, id, m, mv);

    // 3x5 instance: wrap and key (1,4).
    wrap  = 1'b0;
    prev5 = cols2;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (prev5 == 5'b10000 && cols2 == 5'b00001) wrap = 1'b1;
      prev5 = cols2;
    end
    chk("dut2 wrap", 32'(wrap), 32'd1);

    pressed2[9] = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid2) begin
        if (n < 16) times[n] = i;
        n++;
        chk($sformatf("dut2 id p%0d", n), 32'(id2), 32'h0C);
      end
    end
`ifdef KEYB_REPEAT_EN
    chk("dut2 repeat count", 32'(n >= 4), 32'd1);
    for (int k = 1; k < n && k < 16; k++)
      chk($sformatf("dut2 gap %0d", k),
          32'(times[k] - times[k-1]), 32'd16);
`else
    chk("dut2 single pulse", 32'(n), 32'd1);
`endif
    chk("dut2 held", 32'(held2), 32'd1);
    pressed2 = '0;
    repeat (10) @(negedge clk);
    chk("dut2 held@10", 32'(held2), 32'd1);
    @(negedge clk);
    chk("dut2 held@11", 32'(held2), 32'd0);
    chk("dut2 id kept", 32'(id2), 32'h0C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyb_scan_gen.md
KEYB_SCAN_GEN -- requirements
Module: keyb_scan_gen

Interface
REQ-001 Parameter N_ROWS, default 4: number of keypad rows (2..8).
REQ-002 Parameter N_COLS, default 4: number of keypad columns (2..8).
REQ-003 Parameter SCAN_DIV, default 4: clock cycles each column is driven while scanning (>=3).
REQ-004 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles to accept a press or a release (>=1).
REQ-005 Parameter REPEAT_CYCLES, default 64: auto-repeat period in cycles; used only with KEYB_REPEAT_EN.
REQ-006 clk  input  1: single clock; all logic on the rising edge.
REQ-007 reset  input  1: asynchronous, active-low reset (0 = reset).
REQ-008 rows_in  input  N_ROWS: keypad row sense, active-high, asynchronous to clk.
REQ-009 cols_out  output  N_COLS: one-hot column drive.
REQ-010 key_valid  output  1: one-cycle pulse for each accepted key event.
REQ-011 key_id  output  RW+CW: {row index, column index}, binary; RW = clog2(N_ROWS), CW = clog2(N_COLS).
REQ-012 key_held  output  1: high while the accepted key remains pressed.
REQ-013 multi_err  output  1: one-cycle pulse when more than one row is seen in the locked column.

Function
REQ-014 rows_in SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value rs.
REQ-015 The FSM SHALL have exactly four states: SCAN, DEB_PRESS, HELD, DEB_REL.
REQ-016 SCAN: cols_out SHALL rotate one position left every SCAN_DIV cycles, wrapping from bit N_COLS-1 to bit 0.
REQ-017 SCAN: on the last dwell cycle of a column, if rs has exactly one bit set, the FSM SHALL capture that row, keep the column and go to DEB_PRESS.
REQ-018 SCAN: if rs has more than one bit set on the last dwell cycle, the block SHALL pulse multi_err, SHALL NOT pulse key_valid, and SHALL keep rotating.
REQ-019 DEB_PRESS: a counter SHALL count cycles with rs equal to the captured one-hot row; any mismatch SHALL return to SCAN with the column advanced and no pulse.
REQ-020 DEB_PRESS: when the count reaches DEBOUNCE_CYCLES, in the same cycle: key_valid=1, key_id updated, key_held=1, state goes to HELD.
REQ-021 HELD: cols_out SHALL stay frozen; when the captured row bit of rs goes 0, state goes to DEB_REL with the counter cleared.
REQ-022 DEB_REL: DEBOUNCE_CYCLES consecutive cycles with the captured row bit 0 SHALL deassert key_held and return to SCAN on the next column.
REQ-023 DEB_REL: the row bit returning to 1 before the count completes SHALL return to HELD with no new key_valid.
REQ-024 key_id SHALL hold its last accepted value until the next accepted event.
REQ-025 The counters SHALL saturate, never wrap, and SHALL be sized clog2(max(SCAN_DIV, DEBOUNCE_CYCLES, REPEAT_CYCLES)+1).

Reset
REQ-026 While reset is 0: state=SCAN, cols_out=1 (column 0), key_valid=0, key_id=0, key_held=0, multi_err=0, synchroniser and counters cleared.
REQ-027 Reset asserted mid-press SHALL abort immediately; after release of reset, scanning SHALL restart at column 0 and a still-held key SHALL be re-debounced as a new press.

Configuration
REQ-028 Macro KEYB_REPEAT_EN: when defined, in HELD key_valid SHALL pulse again with the same key_id every REPEAT_CYCLES cycles, the first repeat REPEAT_CYCLES after the initial pulse.
REQ-029 Without KEYB_REPEAT_EN: exactly one key_valid per accepted press, no repeat counter logic present.

Structure
REQ-030 Package keyb_pkg SHALL hold the FSM state typedef (SCAN, DEB_PRESS, HELD, DEB_REL) and the default parameter constants.
REQ-031 Sub-module keyb_row_enc SHALL convert the N_ROWS vector to {onehot_ok, multi, row_index} combinationally; the top instantiates it once.

Verification
REQ-032 Defaults; key (row 2, col 1) held 500 ns at a 10 ns clock -> exactly one key_valid, key_id=8'h?? per width: {2'd2,2'd1}=4'b1001, key_held high until 8 cycles after release.
REQ-033 Row 3 / col 3 bouncing (20/50/40/40 ns toggles), then stable for 600 ns -> no pulse during the bounce, a single pulse with key_id=4'b1111 once stable.
REQ-034 Rows 0 and 3 pressed together in column 0 -> multi_err pulses at least once, key_valid stays 0, cols_out keeps rotating.
REQ-035 Reset pulled low 3 cycles into HELD -> all outputs 0, cols_out=4'b0001 while low; the key still held after reset release -> new key_valid after debounce.
REQ-036 N_ROWS=3, N_COLS=5, KEYB_REPEAT_EN, REPEAT_CYCLES=16; key (1,4) held 100 cycles -> initial pulse plus repeats every 16 cycles, key_id=5'b01100, cols_out wraps 5'b10000->5'b00001.
